branch_resolve_ctrl: RTL and testbench

Sequencer for control transfers in the CPU pipeline. Accepts one branch/jump per decode slot together with its condition code from the decode-stage condition decoder. It holds decode until the execute-stage comparison flags for that branch arrive, then issues a one-cycle PC redirect and front-end flush when the transfer is taken. It sits between decode (condition code, target) and execute (compare flags), and drives the fetch PC mux and the IF/ID flush.

---
 rtl/branch_ctrl_pkg.sv | 21 ++
 rtl/branch_resolve_ctrl_cond_eval.sv | 26 ++
 rtl/branch_resolve_ctrl.sv | 123 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared condition-code encodings and the branch sequencer state type.
package branch_ctrl_pkg;

  // Condition encodings, as produced by the decode-stage condition decoder
  localparam int unsigned COND_WIRENUM = 3;

  localparam logic [COND_WIRENUM-1:0] COND_NOP = 3'd0;
  localparam logic [COND_WIRENUM-1:0] COND_L   = 3'd1;
  localparam logic [COND_WIRENUM-1:0] COND_G   = 3'd2;
  localparam logic [COND_WIRENUM-1:0] COND_E   = 3'd3;
  localparam logic [COND_WIRENUM-1:0] COND_NE  = 3'd4;
  localparam logic [COND_WIRENUM-1:0] COND_LE  = 3'd5;
  localparam logic [COND_WIRENUM-1:0] COND_GE  = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    REDIRECT = 2'd2
  } brc_state_t;

endpackage

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// Branch condition evaluator: maps a condition code and EX compare flags
// to a taken decision. Purely combinational.
module cond_eval
  import branch_ctrl_pkg::*;
(
  input  logic [COND_WIRENUM-1:0] cond,
  input  logic                    lt,
  input  logic                    zero,
  output logic                    taken
);

  // Condition table; unknown codes resolve not-taken
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_L:  taken = lt;
      COND_G:  taken = !lt && !zero;
      COND_E:  taken = zero;
      COND_NE: taken = !zero;
      COND_LE: taken = lt || zero;
      COND_GE: taken = !lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Control-transfer sequencer: accepts one jump/branch from decode, holds the
// front end until EX flags resolve the branch, then issues a one-cycle PC
// redirect plus IF/ID flush for taken transfers. Keeps accept/taken counts.
module branch_resolve_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic                    id_jump,
  input  logic                    id_branch,
  input  logic [COND_WIRENUM-1:0] id_cond,
  input  logic [31:0]             id_target,
  input  logic                    ex_flag_valid,
  input  logic                    ex_lt,
  input  logic                    ex_zero,
  input  logic                    ex_kill,
  output logic                    id_ready,
  output logic                    stall,
  output logic                    redir_valid,
  output logic [31:0]             redir_pc,
  output logic                    flush,
  output logic [CNT_W-1:0]        br_cnt,
  output logic [CNT_W-1:0]        taken_cnt
);

  brc_state_t              state;
  logic [COND_WIRENUM-1:0] cond_q;
  logic [31:0]             target_q;
  logic [CNT_W-1:0]        br_cnt_q;
  logic [CNT_W-1:0]        taken_cnt_q;
  logic                    ready_q;
  logic                    stall_q;
  logic                    redir_q;
  logic                    accept;
  logic                    br_taken;

  // Exactly one of jump/branch must be set; both or neither is not a transfer
  assign accept = id_valid && (id_jump ^ id_branch) && (state == IDLE);

  cond_eval u_cond_eval (
    .cond  (cond_q),
    .lt    (ex_lt),
    .zero  (ex_zero),
    .taken (br_taken)
  );

  // Sequencer FSM with registered status outputs, latches and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cond_q      <= '0;
      target_q    <= '0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
      ready_q     <= 1'b1;
      stall_q     <= 1'b0;
      redir_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            br_cnt_q <= br_cnt_q + CNT_W'(1);
            cond_q   <= id_cond;
            target_q <= id_target;
            if (id_jump) begin
              state   <= REDIRECT;
              ready_q <= 1'b0;
              stall_q <= 1'b1;
              redir_q <= 1'b1;
            end else if (id_cond != COND_NOP) begin
              state   <= WAIT;
              ready_q <= 1'b0;
              stall_q <= 1'b1;
              redir_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (ex_kill || (ex_flag_valid && !br_taken)) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            stall_q <= 1'b0;
            redir_q <= 1'b0;
          end else if (ex_flag_valid) begin
            state   <= REDIRECT;
            ready_q <= 1'b0;
            stall_q <= 1'b1;
            redir_q <= 1'b1;
          end
        end
        REDIRECT: begin
          if (!ex_kill) begin
            taken_cnt_q <= taken_cnt_q + CNT_W'(1);
          end
          state   <= IDLE;
          ready_q <= 1'b1;
          stall_q <= 1'b0;
          redir_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          stall_q <= 1'b0;
          redir_q <= 1'b0;
        end
      endcase
    end
  end

  // A kill arriving in the redirect cycle must suppress that very strobe,
  // so ex_kill is the one input that gates an output combinationally.
  assign redir_valid = redir_q && !ex_kill;
  assign flush       = redir_q && !ex_kill;
  assign id_ready    = ready_q;
  assign stall       = stall_q;
  assign redir_pc    = target_q;
  assign br_cnt      = br_cnt_q;
  assign taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios with
// hand-computed expectations, then randomized traffic against a
// transaction-level model. Narrow counters make wrap-around reachable.
module tb_branch_resolve_ctrl;
  import branch_ctrl_pkg::*;

  localparam int unsigned CW   = 8;
  localparam int unsigned CMOD = 1 << CW;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    id_valid = 1'b0;
  logic                    id_jump = 1'b0;
  logic                    id_branch = 1'b0;
  logic [COND_WIRENUM-1:0] id_cond = '0;
  logic [31:0]             id_target = '0;
  logic                    ex_flag_valid = 1'b0;
  logic                    ex_lt = 1'b0;
  logic                    ex_zero = 1'b0;
  logic                    ex_kill = 1'b0;
  logic                    id_ready;
  logic                    stall;
  logic                    redir_valid;
  logic [31:0]             redir_pc;
  logic                    flush;
  logic [CW-1:0]           br_cnt;
  logic [CW-1:0]           taken_cnt;

  int unsigned total = 0;
  int unsigned bad = 0;

  // Transaction-level model: an outstanding conditional transfer awaiting
  // flags, and/or a redirect strobe due in the current cycle.
  bit          m_pend;
  logic [2:0]  m_cond;
  logic [31:0] m_tgt;
  bit          m_redir;
  int unsigned m_br;
  int unsigned m_tk;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_jump       (id_jump),
    .id_branch     (id_branch),
    .id_cond       (id_cond),
    .id_target     (id_target),
    .ex_flag_valid (ex_flag_valid),
    .ex_lt         (ex_lt),
    .ex_zero       (ex_zero),
    .ex_kill       (ex_kill),
    .id_ready      (id_ready),
    .stall         (stall),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .flush         (flush),
    .br_cnt        (br_cnt),
    .taken_cnt     (taken_cnt)
  );

  // Truth table per condition, indexed by {lt, zero}
  function automatic bit rule_taken(logic [2:0] c, logic lt, logic z);
    logic [3:0] mask;
    int idx;
    idx = int'({lt, z});
    case (c)
      COND_L:  mask = 4'b1100;
      COND_G:  mask = 4'b0001;
      COND_E:  mask = 4'b1010;
      COND_NE: mask = 4'b0101;
      COND_LE: mask = 4'b1110;
      COND_GE: mask = 4'b0011;
      default: mask = 4'b0000;
    endcase
    return mask[idx];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = 1'b0;
    m_cond  = '0;
    m_tgt   = '0;
    m_redir = 1'b0;
    m_br    = 0;
    m_tk    = 0;
  endtask

  // Called at a falling edge with inputs already driven: compare, advance
  // the model, and return at the next falling edge.
  task automatic step();
    bit busy;
    bit exp_rv;
    #1;
    busy   = m_pend || m_redir;
    exp_rv = m_redir && !ex_kill;
    chk("id_ready", 32'(id_ready), 32'(!busy));
    chk("stall", 32'(stall), 32'(busy));
    chk("redir_valid", 32'(redir_valid), 32'(exp_rv));
    chk("flush", 32'(flush), 32'(exp_rv));
    if (exp_rv) chk("redir_pc", redir_pc, m_tgt);
    chk("br_cnt", 32'(br_cnt), m_br);
    chk("taken_cnt", 32'(taken_cnt), m_tk);
    if (m_redir) begin
      m_redir = 1'b0;
      if (!ex_kill) m_tk = (m_tk + 1) % CMOD;
    end else if (m_pend) begin
      if (ex_kill) begin
        m_pend = 1'b0;
      end else if (ex_flag_valid) begin
        m_pend  = 1'b0;
        m_redir = rule_taken(m_cond, ex_lt, ex_zero);
      end
    end else if (id_valid && (id_jump != id_branch)) begin
      m_br  = (m_br + 1) % CMOD;
      m_tgt = id_target;
      if (id_jump) begin
        m_redir = 1'b1;
      end else if (id_cond != COND_NOP) begin
        m_pend = 1'b1;
        m_cond = id_cond;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input bit v, input bit j, input bit b, input logic [2:0] c,
                     input logic [31:0] t, input bit fv, input bit lt, input bit z,
                     input bit k);
    id_valid      = v;
    id_jump       = j;
    id_branch     = b;
    id_cond       = c;
    id_target     = t;
    ex_flag_valid = fv;
    ex_lt         = lt;
    ex_zero       = z;
    ex_kill       = k;
    step();
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    int unsigned stall_n;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst id_ready", 32'(id_ready), 32'd1);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst redir_valid", 32'(redir_valid), 32'd0);
    chk("rst flush", 32'(flush), 32'd0);
    chk("rst redir_pc", redir_pc, 32'd0);
    chk("rst br_cnt", 32'(br_cnt), 32'd0);
    chk("rst taken_cnt", 32'(taken_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Jump: redirect in the following cycle
    cyc(1, 1, 0, COND_NOP, 32'h0040_0100, 0, 0, 0, 0);
    chk("jump redir_valid", 32'(redir_valid), 32'd1);
    chk("jump redir_pc", redir_pc, 32'h0040_0100);
    chk("jump br_cnt", 32'(br_cnt), 32'd1);
    idle();
    chk("jump taken_cnt", 32'(taken_cnt), 32'd1);
    chk("jump back idle", 32'(id_ready), 32'd1);

    // COND_E, flags arrive three cycles after accept
    cyc(1, 0, 1, COND_E, 32'h0000_2000, 0, 0, 0, 0);
    stall_n = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall) stall_n++;
      cyc(0, 0, 0, '0, '0, (i == 2), 0, 1, 0);
    end
    chk("cond_e stall cycles", stall_n, 32'd3);
    chk("cond_e redirect", 32'(redir_valid), 32'd1);
    idle();
    chk("cond_e taken_cnt", 32'(taken_cnt), 32'd2);

    // COND_GE with lt=1 is not taken
    cyc(1, 0, 1, COND_GE, 32'h0000_3000, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, '0, 1, 1, 0, 0);
    chk("ge idle at F+1", 32'(id_ready), 32'd1);
    chk("ge no redirect", 32'(redir_valid), 32'd0);
    chk("ge taken_cnt", 32'(taken_cnt), 32'd2);

    // All six conditions over all four flag combinations
    for (int c = 1; c <= 6; c++) begin
      for (int f = 0; f < 4; f++) begin
        cyc(1, 0, 1, 3'(c), 32'h1000 + 32'(c * 16 + f), 0, 0, 0, 0);
        cyc(0, 0, 0, '0, '0, 1, f[1], f[0], 0);
        idle();
        idle();
      end
    end
    chk("sweep taken_cnt", 32'(taken_cnt), 32'd14);

    // Kill while waiting for flags
    cyc(1, 0, 1, COND_E, 32'h0000_4000, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, '0, 1, 0, 1, 1);
    chk("kill wait idle", 32'(id_ready), 32'd1);
    idle();
    chk("kill wait taken_cnt", 32'(taken_cnt), 32'd14);

    // Kill in the redirect cycle
    cyc(1, 1, 0, COND_NOP, 32'h0000_5000, 0, 0, 0, 0);
    ex_kill = 1'b1;
    #1;
    chk("kill redir_valid", 32'(redir_valid), 32'd0);
    chk("kill flush", 32'(flush), 32'd0);
    step();
    ex_kill = 1'b0;
    chk("kill redir idle", 32'(id_ready), 32'd1);
    chk("kill redir taken_cnt", 32'(taken_cnt), 32'd14);
    chk("br_cnt after directed", 32'(br_cnt), 32'd29);

    // Asynchronous reset in the middle of WAIT
    cyc(1, 0, 1, COND_NE, 32'h0000_6000, 0, 0, 0, 0);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst stall", 32'(stall), 32'd0);
    chk("async rst id_ready", 32'(id_ready), 32'd1);
    chk("async rst br_cnt", 32'(br_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 1, COND_L, 32'h0000_7000, 0, 0, 0, 0);
    cyc(0, 0, 0, '0, '0, 1, 1, 0, 0);
    chk("post rst redirect", 32'(redir_valid), 32'd1);
    chk("post rst redir_pc", redir_pc, 32'h0000_7000);
    idle();
    chk("post rst br_cnt", 32'(br_cnt), 32'd1);
    chk("post rst taken_cnt", 32'(taken_cnt), 32'd1);

    // Drive both counters to all-ones, then one more transfer wraps them
    for (int i = 0; i < 254; i++) begin
      cyc(1, 1, 0, COND_NOP, 32'(i), 0, 0, 0, 0);
      idle();
    end
    chk("pre-wrap br_cnt", 32'(br_cnt), 32'd255);
    chk("pre-wrap taken_cnt", 32'(taken_cnt), 32'd255);
    cyc(1, 1, 0, COND_NOP, 32'h0000_8000, 0, 0, 0, 0);
    idle();
    chk("wrap br_cnt", 32'(br_cnt), 32'd0);
    chk("wrap taken_cnt", 32'(taken_cnt), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      cyc(($urandom % 4) != 0, 1'($urandom), 1'($urandom), 3'($urandom), $urandom,
          ($urandom % 3) == 0, 1'($urandom), 1'($urandom), ($urandom % 10) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
